imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, instruction-memory word-address width (depth 2^ADDR_WIDTH words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a (re)load.
REQ-005 in_valid  input  1  byte available on in_data.
REQ-006 in_data  input  8  program byte stream, little-endian per word.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_WIDTH  word index of the write.
REQ-010 imem_wdata  output  32  assembled instruction word.
REQ-011 cpu_reset  output  1  holds the CPU in reset while not loaded.
REQ-012 load_done  output  1  program fully loaded, CPU released.
REQ-013 overflow  output  1  program exceeded memory depth without a terminator.
REQ-014 word_count  output  ADDR_WIDTH+1  words written in current load, terminator included.

Function
REQ-015 FSM states SHALL be IDLE, RECV, WRITE, DONE, ERROR; all outputs registered or decoded from state only.
REQ-016 Byte handshake SHALL complete only on a cycle with in_valid=1 and in_ready=1; in_ready=1 only in RECV.
REQ-017 IDLE: start=1 -> RECV next cycle; byte lane, imem_addr, word_count, overflow cleared.
REQ-018 RECV: accepted byte k (k=0..3) SHALL land in word bits [8k+7:8k]; after the 4th accepted byte -> WRITE.
REQ-019 WRITE: imem_we=1 for exactly one cycle, imem_wdata = assembled word, imem_addr = current index; word_count increments in the same cycle.
REQ-020 Latency: imem_we SHALL assert the cycle immediately after the 4th byte handshake; minimum throughput one word per 5 cycles.
REQ-021 Terminator: word 0x00000000 SHALL be written, then WRITE -> DONE.
REQ-022 Non-terminator written at imem_addr = 2^ADDR_WIDTH-1 SHALL go WRITE -> ERROR; otherwise imem_addr increments and WRITE -> RECV.
REQ-023 DONE: load_done=1, cpu_reset=0, in_ready=0; start=1 -> RECV (reload), cpu_reset reasserted and load_done cleared the next cycle.
REQ-024 ERROR: overflow=1, cpu_reset=1, load_done=0, in_ready=0; exit only via start (-> RECV, overflow cleared) or reset.
REQ-025 start SHALL be ignored in RECV and WRITE; in_valid with in_ready=0 SHALL be ignored and not stall.
REQ-026 cpu_reset SHALL be 1 in every state except DONE.
REQ-027 Partial word (fewer than 4 bytes) SHALL never be written; it is discarded on reset or reload.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE with cpu_reset=1, load_done=0, overflow=0, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, byte lane 0.
REQ-029 reset SHALL take priority over start and in_valid in the same cycle, including mid-word and during WRITE (no write strobe that cycle).

Verification
REQ-030 Load bytes 13 00 00 00, 93 00 10 00, 00 00 00 00 with in_valid held -> writes 0x00000013@0, 0x00100093@1, 0x00000000@2; word_count=3; load_done=1, cpu_reset=0.
REQ-031 in_valid toggled every other cycle on the same stream -> identical writes; each imem_we exactly one cycle after the 4th byte handshake.
REQ-032 ADDR_WIDTH=2, five nonzero words -> four writes (addr 0..3), then ERROR: overflow=1, cpu_reset=1, fifth word never written.
REQ-033 reset asserted after 2 bytes of word 1 -> IDLE outputs per REQ-028; subsequent start plus full stream loads from addr 0.
REQ-034 start in DONE, new stream 37 05 00 00, 00 00 00 00 -> cpu_reset=1 next cycle, writes 0x00000537@0, 0@1, load_done=1, word_count=2.
REQ-035 start pulsed mid-word in RECV -> ignored; byte assembly and addresses unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words, writes them to IMEM and holds the CPU in reset until a zero terminator.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            lane;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           word_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  handshake;
    logic                  word_is_term;
    logic                  addr_is_last;

    assign handshake    = in_valid && in_ready;
    assign word_is_term = (word_q == '0);
    assign addr_is_last = (addr_q == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RECV;
            RECV:    if (handshake && lane == 2'd3) state_nxt = WRITE;
            WRITE: begin
                if (word_is_term)      state_nxt = DONE;
                else if (addr_is_last) state_nxt = ERROR;
                else                   state_nxt = RECV;
            end
            DONE:    if (start) state_nxt = RECV;
            ERROR:   if (start) state_nxt = RECV;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath; start is only honoured outside RECV/WRITE, which discards any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane    <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        lane    <= '0;
                        addr_q  <= '0;
                        count_q <= '0;
                    end
                end
                RECV: begin
                    if (handshake) begin
                        word_q[{lane, 3'b000} +: 8] <= in_data;
                        lane                        <= lane + 2'd1;
                    end
                end
                WRITE: begin
                    count_q <= count_q + 1'b1;
                    if (!word_is_term && !addr_is_last) begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == RECV);
    assign imem_we    = (state == WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign cpu_reset  = (state != DONE);
    assign load_done  = (state == DONE);
    assign overflow   = (state == ERROR);
    assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a cycle-accurate vector table plus hand-written
// sequences for throttled input, reset mid-load, reload and overflow.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        a_rdy, a_we, a_cr, a_ld, a_ov;
    logic [9:0]  a_addr;
    logic [31:0] a_wd;
    logic [10:0] a_wc;

    logic        b_rdy, b_we, b_cr, b_ld, b_ov;
    logic [1:0]  b_addr;
    logic [31:0] b_wd;
    logic [2:0]  b_wc;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [41:0] log_a[$];
    logic [41:0] log_b[$];

    always #5 clk = ~clk;

    imem_loader u_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_rdy), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wd),
        .cpu_reset(a_cr), .load_done(a_ld), .overflow(a_ov), .word_count(a_wc)
    );

    imem_loader #(.ADDR_WIDTH(2)) u_b (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_rdy), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wd),
        .cpu_reset(b_cr), .load_done(b_ld), .overflow(b_ov), .word_count(b_wc)
    );

    always @(negedge clk) begin
        if (a_we) log_a.push_back({a_addr, a_wd});
        if (b_we) log_b.push_back({8'h00, b_addr, b_wd});
    end

    // flags = {in_ready, imem_we, cpu_reset, load_done, overflow}
    typedef struct {
        logic [2:0]  ctl;   // {reset, start, in_valid}
        logic [7:0]  data;
        logic [4:0]  flags;
        logic [10:0] wc;
        logic        chk_dp;
        logic [9:0]  addr;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [2:0] ctl, input logic [7:0] data,
                               input logic [4:0] flags, input logic [10:0] wc,
                               input logic chk_dp, input logic [9:0] addr,
                               input logic [31:0] wd);
        vec_t r;
        r.ctl = ctl; r.data = data; r.flags = flags; r.wc = wc;
        r.chk_dp = chk_dp; r.addr = addr; r.wd = wd;
        return r;
    endfunction

    localparam logic [4:0] F_IDLE  = 5'b00100;
    localparam logic [4:0] F_RECV  = 5'b10100;
    localparam logic [4:0] F_WRITE = 5'b01100;
    localparam logic [4:0] F_DONE  = 5'b00010;
    localparam logic [4:0] F_ERROR = 5'b00101;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns just after the rising edge on which the byte was accepted by DUT A.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bit got = 1'b0;
        for (int unsigned g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20; k++) begin
            if (a_rdy) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("byte handshake", 64'(got), 64'd1);
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        for (int unsigned i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
        #1;
        chk("we one cycle after 4th byte", 64'(a_we), 64'd1);
        chk("wdata on write", 64'(a_wd), 64'(w));
    endtask

    task automatic idle_input();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_prog3(input string tag);
        chk({tag, " write count"}, 64'(log_a.size()), 64'd3);
        if (log_a.size() == 3) begin
            chk({tag, " write0"}, 64'(log_a[0]), {22'd0, 10'd0, 32'h00000013});
            chk({tag, " write1"}, 64'(log_a[1]), {22'd0, 10'd1, 32'h00100093});
            chk({tag, " write2"}, 64'(log_a[2]), {22'd0, 10'd2, 32'h00000000});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Load 13 00 00 00 / 93 00 10 00 / 00 00 00 00, then reload 37 05 00 00 / 0.
        vecs.push_back(v(3'b100, 8'h00, F_IDLE,  11'd0, 1'b1, 10'd0, 32'h0));
        vecs.push_back(v(3'b010, 8'h00, F_RECV,  11'd0, 1'b0, 10'd0, 32'h0));
        vecs.push_back(v(3'b001, 8'h13, F_RECV,  11'd0, 1'b0, 10'd0, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_RECV,  11'd0, 1'b0, 10'd0, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_RECV,  11'd0, 1'b0, 10'd0, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_WRITE, 11'd0, 1'b1, 10'd0, 32'h00000013));
        vecs.push_back(v(3'b001, 8'hAA, F_RECV,  11'd1, 1'b1, 10'd1, 32'h00000013));
        vecs.push_back(v(3'b000, 8'h00, F_RECV,  11'd1, 1'b0, 10'd1, 32'h0));
        vecs.push_back(v(3'b001, 8'h93, F_RECV,  11'd1, 1'b0, 10'd1, 32'h0));
        vecs.push_back(v(3'b011, 8'h00, F_RECV,  11'd1, 1'b0, 10'd1, 32'h0));
        vecs.push_back(v(3'b001, 8'h10, F_RECV,  11'd1, 1'b0, 10'd1, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_WRITE, 11'd1, 1'b1, 10'd1, 32'h00100093));
        vecs.push_back(v(3'b001, 8'h00, F_RECV,  11'd2, 1'b0, 10'd2, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_RECV,  11'd2, 1'b0, 10'd2, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_RECV,  11'd2, 1'b0, 10'd2, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_RECV,  11'd2, 1'b0, 10'd2, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_WRITE, 11'd2, 1'b1, 10'd2, 32'h00000000));
        vecs.push_back(v(3'b001, 8'h55, F_DONE,  11'd3, 1'b0, 10'd0, 32'h0));
        vecs.push_back(v(3'b001, 8'h66, F_DONE,  11'd3, 1'b0, 10'd0, 32'h0));
        vecs.push_back(v(3'b010, 8'h00, F_RECV,  11'd0, 1'b0, 10'd0, 32'h0));
        vecs.push_back(v(3'b001, 8'h37, F_RECV,  11'd0, 1'b0, 10'd0, 32'h0));
        vecs.push_back(v(3'b001, 8'h05, F_RECV,  11'd0, 1'b0, 10'd0, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_RECV,  11'd0, 1'b0, 10'd0, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_WRITE, 11'd0, 1'b1, 10'd0, 32'h00000537));
        vecs.push_back(v(3'b000, 8'h00, F_RECV,  11'd1, 1'b0, 10'd1, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_RECV,  11'd1, 1'b0, 10'd1, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_RECV,  11'd1, 1'b0, 10'd1, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_RECV,  11'd1, 1'b0, 10'd1, 32'h0));
        vecs.push_back(v(3'b001, 8'h00, F_WRITE, 11'd1, 1'b1, 10'd1, 32'h00000000));
        vecs.push_back(v(3'b000, 8'h00, F_DONE,  11'd2, 1'b0, 10'd0, 32'h0));

        foreach (vecs[i]) begin
            @(negedge clk);
            {reset, start, in_valid} = vecs[i].ctl;
            in_data = vecs[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d flags", i), 64'({a_rdy, a_we, a_cr, a_ld, a_ov}), 64'(vecs[i].flags));
            chk($sformatf("vec%0d word_count", i), 64'(a_wc), 64'(vecs[i].wc));
            if (vecs[i].chk_dp) begin
                chk($sformatf("vec%0d imem_addr", i), 64'(a_addr), 64'(vecs[i].addr));
                chk($sformatf("vec%0d imem_wdata", i), 64'(a_wd), 64'(vecs[i].wd));
            end
        end
        idle_input();

        // Throttled stream: in_valid toggles every other cycle.
        do_reset();
        log_a.delete();
        do_start();
        send_word(32'h00000013, 1);
        send_word(32'h00100093, 1);
        send_word(32'h00000000, 1);
        idle_input();
        @(posedge clk); #1;
        chk("throttled flags", 64'({a_rdy, a_we, a_cr, a_ld, a_ov}), 64'(F_DONE));
        chk("throttled word_count", 64'(a_wc), 64'd3);
        chk_prog3("throttled");

        // Reset after two bytes of word 1, then a clean load from address 0.
        do_reset();
        do_start();
        send_word(32'h11223344, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midword reset flags", 64'({a_rdy, a_we, a_cr, a_ld, a_ov}), 64'(F_IDLE));
        chk("midword reset addr", 64'(a_addr), 64'd0);
        chk("midword reset wdata", 64'(a_wd), 64'd0);
        chk("midword reset word_count", 64'(a_wc), 64'd0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        log_a.delete();
        do_start();
        send_word(32'h00000013, 0);
        send_word(32'h00100093, 0);
        send_word(32'h00000000, 0);
        idle_input();
        @(posedge clk); #1;
        chk("reload after reset flags", 64'({a_rdy, a_we, a_cr, a_ld, a_ov}), 64'(F_DONE));
        chk_prog3("reload after reset");

        // Reset coinciding with the 4th byte handshake, then reset while in WRITE.
        do_reset();
        log_a.delete();
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h04; reset = 1'b1;
        @(posedge clk); #1;
        chk("reset on 4th byte we", 64'(a_we), 64'd0);
        chk("reset on 4th byte flags", 64'({a_rdy, a_we, a_cr, a_ld, a_ov}), 64'(F_IDLE));
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset on 4th byte no write", 64'(log_a.size()), 64'd0);
        do_start();
        send_word(32'h0A0B0C0D, 0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("reset in WRITE flags", 64'({a_rdy, a_we, a_cr, a_ld, a_ov}), 64'(F_IDLE));
        chk("reset in WRITE word_count", 64'(a_wc), 64'd0);
        chk("reset in WRITE addr", 64'(a_addr), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Overflow on the ADDR_WIDTH=2 instance: five nonzero words, no terminator.
        do_reset();
        log_b.delete();
        do_start();
        for (int unsigned w = 1; w <= 5; w++) send_word(32'(w), 0);
        idle_input();
        @(posedge clk); #1;
        chk("overflow write count", 64'(log_b.size()), 64'd4);
        for (int unsigned i = 0; i < 4 && i < log_b.size(); i++)
            chk($sformatf("overflow write%0d", i), 64'(log_b[i]), {22'd0, 8'd0, 2'(i), 32'(i + 1)});
        chk("overflow flags", 64'({b_rdy, b_we, b_cr, b_ld, b_ov}), 64'(F_ERROR));
        chk("overflow word_count", 64'(b_wc), 64'd4);
        repeat (2) @(negedge clk);
        chk("error holds without start", 64'({b_rdy, b_we, b_cr, b_ld, b_ov}), 64'(F_ERROR));
        do_start();
        chk("start from ERROR flags", 64'({b_rdy, b_we, b_cr, b_ld, b_ov}), 64'(F_RECV));
        chk("start from ERROR word_count", 64'(b_wc), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
